tdc_meas_ctrl: RTL

TDC_MEAS_CTRL -- requirements
Module: tdc_meas_ctrl

---
 rtl/tdc_meas_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/tdc_meas_ctrl.sv
// Measurement-run controller for a TDC: clears the TDC, drives the modulation square wave,
// then streams per-sample results (or, with TDC_CTRL_AVG_EN defined, one accumulated sum).
module tdc_meas_ctrl #(
  parameter int MOD_W = 16,
  parameter int NS_W  = 8,
  parameter int D_W   = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [MOD_W-1:0]    mod_half,
  input  logic [NS_W-1:0]     n_samples,
  input  logic [MOD_W-1:0]    timeout_cyc,
  output logic                mod,
  output logic                tdc_rst_n,
  input  logic [D_W-1:0]      frac_part,
  input  logic [D_W-1:0]      int_part,
  input  logic                wrena,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [D_W+NS_W-1:0] res_frac,
  output logic [D_W+NS_W-1:0] res_int,
  output logic [NS_W-1:0]     res_idx,
  output logic                busy,
  output logic                done,
  output logic                timeout_err,
  output logic                overrun
);

  localparam int R_W = D_W + NS_W;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

  state_t state, state_nx;

  logic [MOD_W-1:0] mod_half_q, timeout_q, mod_cnt, to_cnt;
  logic [NS_W-1:0]  n_q, cnt;
  logic             clr_cnt, mod_q, tdc_en_q;
  logic [R_W-1:0]   res_frac_q, res_int_q;
  logic [NS_W-1:0]  res_idx_q;
  logic             res_valid_q, done_q, tmo_q, overrun_q;
  logic             accept, xfer, last, timed_out;

`ifdef TDC_CTRL_AVG_EN
  logic [R_W-1:0]   sum_frac, sum_int;
`endif

  // NOTE: every signal written here gets a default first so no path leaves it unassigned,
  // which is what keeps this block from inferring latches.
  always_comb begin
    accept    = (state == RUN) && wrena;
    xfer      = res_valid_q && res_ready;
    last      = accept && ((NS_W+1)'(cnt) + (NS_W+1)'(1) == (NS_W+1)'(n_q));
    timed_out = (state == RUN) && !wrena && (timeout_q != '0) &&
                (to_cnt + MOD_W'(1) == timeout_q);

    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CLEAR;
      CLEAR:   if (clr_cnt) state_nx = RUN;
      RUN: begin
        if (timed_out)   state_nx = IDLE;
        else if (last)   state_nx = DRAIN;
      end
      DRAIN:   if (!res_valid_q) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    busy        = (state != IDLE);
    tdc_rst_n   = tdc_en_q && (state != CLEAR);
    mod         = mod_q;
    res_valid   = res_valid_q;
    res_frac    = res_frac_q;
    res_int     = res_int_q;
    res_idx     = res_idx_q;
    done        = done_q;
    timeout_err = tmo_q;
    overrun     = overrun_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // NOTE: the result registers are ordinary flops, not a memory, so they are reset
  // along with everything else to present zeros after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mod_half_q  <= '0;
      timeout_q   <= '0;
      n_q         <= '0;
      cnt         <= '0;
      mod_cnt     <= '0;
      to_cnt      <= '0;
      clr_cnt     <= 1'b0;
      mod_q       <= 1'b0;
      tdc_en_q    <= 1'b0;
      res_frac_q  <= '0;
      res_int_q   <= '0;
      res_idx_q   <= '0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef TDC_CTRL_AVG_EN
      sum_frac    <= '0;
      sum_int     <= '0;
`endif
    end else begin
      tdc_en_q <= 1'b1;
      done_q   <= 1'b0;

      if (state == IDLE && start) begin
        mod_half_q <= (mod_half == '0) ? MOD_W'(1) : mod_half;
        n_q        <= (n_samples == '0) ? NS_W'(1) : n_samples;
        timeout_q  <= timeout_cyc;
        cnt        <= '0;
        tmo_q      <= 1'b0;
        overrun_q  <= 1'b0;
      end

      clr_cnt <= (state == CLEAR) ? ~clr_cnt : 1'b0;

      // Counting only while staying in RUN keeps mod low on both the entry and exit edges.
      if (state == RUN && state_nx == RUN) begin
        if (mod_cnt + MOD_W'(1) == mod_half_q) begin
          mod_cnt <= '0;
          mod_q   <= ~mod_q;
        end else begin
          mod_cnt <= mod_cnt + MOD_W'(1);
        end
      end else begin
        mod_cnt <= '0;
        mod_q   <= 1'b0;
      end

      if (state == RUN && !wrena) to_cnt <= to_cnt + MOD_W'(1);
      else                        to_cnt <= '0;

      if (accept) cnt <= cnt + NS_W'(1);

`ifdef TDC_CTRL_AVG_EN
      if (state == CLEAR) begin
        sum_frac <= '0;
        sum_int  <= '0;
      end else if (accept) begin
        sum_frac <= sum_frac + R_W'(frac_part);
        sum_int  <= sum_int + R_W'(int_part);
      end

      if (last) begin
        res_frac_q  <= sum_frac + R_W'(frac_part);
        res_int_q   <= sum_int + R_W'(int_part);
        res_idx_q   <= cnt;
        res_valid_q <= 1'b1;
      end else if (xfer) begin
        res_valid_q <= 1'b0;
      end
`else
      // A slot is free when empty or when its current result leaves on this same edge.
      if (accept && (!res_valid_q || res_ready)) begin
        res_frac_q  <= R_W'(frac_part);
        res_int_q   <= R_W'(int_part);
        res_idx_q   <= cnt;
        res_valid_q <= 1'b1;
      end else begin
        if (accept) overrun_q   <= 1'b1;
        if (xfer)   res_valid_q <= 1'b0;
      end
`endif

      if (timed_out) begin
        tmo_q       <= 1'b1;
        res_valid_q <= 1'b0;
      end

      if (state == DRAIN && !res_valid_q) done_q <= 1'b1;
    end
  end

endmodule
